muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//   Sequences the multi-cycle MULT/DIV units that write HI/LO in the MIPS multicycle datapath.
//   Accepts one MULT or DIV request at a time from the main control FSM and latches its operands from A/B.
//   Pulses the selected unit's start, waits for its done, then drives the HI/LO write enables and source select.
//   Stalls MFHI/MFLO and new requests while busy; raises divide-by-zero and timeout exceptions towards the exception muxes.
// PARAMETERS
//   WIDTH           32   operand / result width
//   TIMEOUT_CYCLES  64   max RUN cycles waiting for done before timeout_excp
//   CNT_W           7    RUN counter width; must hold TIMEOUT_CYCLES
// PORTS
//   clk           in   1      system clock, rising edge
//   reset         in   1      asynchronous reset, active-low
//   mult_req      in   1      MULT request, level, held by control until req_ack
//   div_req       in   1      DIV request, level, held by control until req_ack
//   op_a          in   WIDTH  operand from register A
//   op_b          in   WIDTH  operand from register B
//   hilo_read     in   1      control wants MFHI/MFLO this cycle
//   mult_done     in   1      multiplier result valid (one-cycle pulse)
//   div_done      in   1      divider result valid (one-cycle pulse)
//   req_ack       out  1      request accepted (one cycle)
//   mult_start    out  1      multiplier start pulse
//   div_start     out  1      divider start pulse
//   src_a         out  WIDTH  latched operand A to units
//   src_b         out  WIDTH  latched operand B to units
//   hilo_src      out  1      HI/LO input select: 0 = mult, 1 = div
//   hi_write      out  1      HI register write enable
//   lo_write      out  1      LO register write enable
//   busy          out  1      state != IDLE
//   stall         out  1      busy & (hilo_read | mult_req | div_req)
//   div_zero_excp out  1      divide-by-zero exception pulse
//   timeout_excp  out  1      unit failed to finish, exception pulse
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, counter=0, src_a=src_b=0, hilo_src=0, all other outputs 0. Reset mid-operation aborts it with no HI/LO write.
//   - All outputs are registered or decoded from state only. None is combinational from inputs, except stall.
//   - States: IDLE, MULT_RUN, DIV_RUN, WRITE, EXCP.
//   - IDLE, at the edge where a request is sampled:
//       * mult_req=1 (priority over div_req): latch op_a/op_b, hilo_src<=0, go MULT_RUN.
//       * else div_req=1 and op_b!=0: latch operands, hilo_src<=1, go DIV_RUN.
//       * else div_req=1 and op_b==0: go EXCP. No start pulse; operands and hilo_src unchanged.
//       * req_ack=1 in the first cycle of the next state, for one cycle, in every accept case.
//   - First RUN cycle: mult_start or div_start=1 for exactly one cycle, counter<=1.
//       * done in that same cycle is ignored.
//   - Later RUN cycles:
//       * matching done=1 -> WRITE.
//       * non-matching done is ignored.
//       * counter reaches TIMEOUT_CYCLES without done -> timeout_excp=1 for one cycle, then IDLE, no write.
//   - WRITE: hi_write=lo_write=1 for one cycle, hilo_src held, then IDLE.
//       * Latency: req edge -> write cycle = done cycle + 1.
//   - EXCP: div_zero_excp=1 for one cycle, then IDLE. HI/LO never written.
//   - Requests and hilo_read while busy are not accepted; stall is held high.
//       * A request held through the WRITE cycle is accepted on the first IDLE edge; no bubble beyond one IDLE cycle.
//   - mult_req & div_req together: only MULT is accepted. div_req stays pending and is served next.
//   - Counter saturates and never wraps. It is cleared on every entry to IDLE.
// TESTING
//   1) MULT: op_a=7, op_b=6, mult_req held; mult_done 5 cycles after start -> one req_ack, one mult_start, src_a=7, src_b=6, hi/lo_write 1 cycle after done, hilo_src=0.
//   2) DIV by zero: div_req, op_b=0 -> div_zero_excp pulse 1 cycle, no div_start, no hi/lo_write, busy low after 1 cycle.
//   3) Simultaneous mult_req+div_req (op_b=3), both held -> MULT completes first, then DIV starts with hilo_src=1; two writes total.
//   4) DIV, div_done never arrives, TIMEOUT_CYCLES=64 -> timeout_excp exactly 64 RUN cycles after start, no write; done in start cycle ignored.
//   5) hilo_read during DIV_RUN -> stall=1 until WRITE completes, stall=0 in following IDLE cycle.
//   6) reset driven low mid MULT_RUN (async, between edges) -> all outputs 0 immediately; after release a new MULT completes normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequences the multi-cycle MULT/DIV units behind HI/LO: accepts one request,
// pulses the unit start, waits for done, then writes HI/LO or raises an exception.
module muldiv_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_req,
  input  logic             div_req,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_read,
  input  logic             mult_done,
  input  logic             div_done,
  output logic             req_ack,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] src_a,
  output logic [WIDTH-1:0] src_b,
  output logic             hilo_src,
  output logic             hi_write,
  output logic             lo_write,
  output logic             busy,
  output logic             stall,
  output logic             div_zero_excp,
  output logic             timeout_excp
);

  typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, WRITE, EXCP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             first_cycle;
  logic             unit_done;

  // The start pulse marks the first RUN cycle, where a done is ignored.
  assign first_cycle = mult_start | div_start;
  assign unit_done   = (state == MULT_RUN && mult_done) || (state == DIV_RUN && div_done);
  assign busy        = (state != IDLE);
  assign stall       = busy & (hilo_read | mult_req | div_req);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      src_a         <= '0;
      src_b         <= '0;
      hilo_src      <= 1'b0;
      req_ack       <= 1'b0;
      mult_start    <= 1'b0;
      div_start     <= 1'b0;
      hi_write      <= 1'b0;
      lo_write      <= 1'b0;
      div_zero_excp <= 1'b0;
      timeout_excp  <= 1'b0;
    end else begin
      req_ack       <= 1'b0;
      mult_start    <= 1'b0;
      div_start     <= 1'b0;
      hi_write      <= 1'b0;
      lo_write      <= 1'b0;
      div_zero_excp <= 1'b0;
      timeout_excp  <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (mult_req) begin
            src_a      <= op_a;
            src_b      <= op_b;
            hilo_src   <= 1'b0;
            mult_start <= 1'b1;
            req_ack    <= 1'b1;
            count      <= CNT_W'(1);
            state      <= MULT_RUN;
          end else if (div_req) begin
            req_ack <= 1'b1;
            if (op_b != '0) begin
              src_a     <= op_a;
              src_b     <= op_b;
              hilo_src  <= 1'b1;
              div_start <= 1'b1;
              count     <= CNT_W'(1);
              state     <= DIV_RUN;
            end else begin
              div_zero_excp <= 1'b1;
              state         <= EXCP;
            end
          end
        end
        MULT_RUN, DIV_RUN: begin
          // count equals the number of RUN cycles spent so far, saturating at all-ones.
          if (!first_cycle && unit_done) begin
            hi_write <= 1'b1;
            lo_write <= 1'b1;
            state    <= WRITE;
          end else if (!first_cycle && count >= TIMEOUT) begin
            timeout_excp <= 1'b1;
            count        <= '0;
            state        <= IDLE;
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        WRITE: begin
          count <= '0;
          state <= IDLE;
        end
        EXCP: begin
          count <= '0;
          state <= IDLE;
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
